// File: rtl/convb_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : convb_pingpong_ctrl
//  Purpose  : Scheduler for the double-buffered (ping-pong) IFM memory that
//             sits between two conv blocks. The upstream conv CU (producer)
//             writes output feature maps into one bank. The downstream conv
//             CU (consumer) reads the other bank. The block tracks per-bank
//             state, issues start pulses, steers the bank selects, counts
//             consumed frames and flags handshake violations.
//  Ports    : clk          in   rising-edge clock
//             reset        in   synchronous, active-low reset
//             run          in   level; allows new producer frames to start
//             prod_done    in   pulse; producer finished writing wr_bank
//             cons_done    in   pulse; consumer finished reading rd_bank
//             prod_start   out  one-cycle pulse; producer may write wr_bank
//             cons_start   out  one-cycle pulse; consumer may read rd_bank
//             wr_bank      out  bank index being written
//             rd_bank      out  bank index being read
//             bank_full    out  [1:0] bank i is FULL or READING
//             frames_done  out  [CNT_BITS-1:0] frames consumed this layer
//             layer_done   out  one-cycle pulse after FRAME_LIMIT frames
//             proto_err    out  sticky handshake-violation flag
//  Revision : 1.0  initial release
// ============================================================================
module convb_pingpong_ctrl #(
    parameter int FRAME_LIMIT = 16,   // frames per layer pass; 0 = unlimited
    parameter int CNT_BITS    = 8     // 2**CNT_BITS must exceed FRAME_LIMIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                prod_done,
    input  logic                cons_done,
    output logic                prod_start,
    output logic                cons_start,
    output logic                wr_bank,
    output logic                rd_bank,
    output logic [1:0]          bank_full,
    output logic [CNT_BITS-1:0] frames_done,
    output logic                layer_done,
    output logic                proto_err
);

    // Encoding chosen so bit [1] is exactly "holds a frame" (FULL/READING).
    typedef enum logic [1:0] {
        B_EMPTY   = 2'b00,
        B_WRITING = 2'b01,
        B_FULL    = 2'b10,
        B_READING = 2'b11
    } bank_t;

    typedef enum logic { P_IDLE = 1'b0, P_BUSY = 1'b1 } p_state_t;
    typedef enum logic { C_IDLE = 1'b0, C_BUSY = 1'b1 } c_state_t;

    localparam bit                LIMIT_EN  = (FRAME_LIMIT != 0);
    localparam logic [CNT_BITS-1:0] LIMIT_VAL = CNT_BITS'(FRAME_LIMIT);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    p_state_t            p_state, p_state_nxt;
    c_state_t            c_state, c_state_nxt;
    bank_t               bank_st  [2];
    bank_t               bank_nxt [2];
    logic                wr_nxt, rd_nxt;
    logic [CNT_BITS-1:0] produced, produced_nxt;
    logic [CNT_BITS-1:0] frames_nxt;
    logic                prod_start_nxt, cons_start_nxt;
    logic                layer_nxt, err_nxt;
    logic                prod_allowed;
    logic                limit_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_state     <= P_IDLE;
            c_state     <= C_IDLE;
            bank_st     <= '{B_EMPTY, B_EMPTY};
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            produced    <= '0;
            frames_done <= '0;
            prod_start  <= 1'b0;
            cons_start  <= 1'b0;
            layer_done  <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            p_state     <= p_state_nxt;
            c_state     <= c_state_nxt;
            bank_st     <= bank_nxt;
            wr_bank     <= wr_nxt;
            rd_bank     <= rd_nxt;
            produced    <= produced_nxt;
            frames_done <= frames_nxt;
            prod_start  <= prod_start_nxt;
            cons_start  <= cons_start_nxt;
            layer_done  <= layer_nxt;
            proto_err   <= err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Both FSMs look only at registered bank state, so a
    // bank released at an edge is never re-started at that same edge.
    // Within one edge the two FSMs always touch different banks: a start
    // needs EMPTY/FULL while a done needs WRITING/READING on its own bank.
    // ------------------------------------------------------------------
    always_comb begin
        p_state_nxt    = p_state;
        c_state_nxt    = c_state;
        bank_nxt       = bank_st;
        wr_nxt         = wr_bank;
        rd_nxt         = rd_bank;
        produced_nxt   = produced;
        frames_nxt     = frames_done;
        prod_start_nxt = 1'b0;
        cons_start_nxt = 1'b0;
        layer_nxt      = 1'b0;
        err_nxt        = proto_err;

        prod_allowed = !LIMIT_EN || (produced < LIMIT_VAL);
        limit_hit    = LIMIT_EN && (frames_done == LIMIT_VAL);

        // Producer
        case (p_state)
            P_IDLE: begin
                // A done with nothing in flight is dropped and flagged.
                if (prod_done) begin
                    err_nxt = 1'b1;
                end
                if (run && (bank_st[wr_bank] == B_EMPTY) && prod_allowed) begin
                    prod_start_nxt    = 1'b1;
                    bank_nxt[wr_bank] = B_WRITING;
                    p_state_nxt       = P_BUSY;
                end
            end
            P_BUSY: begin
                if (prod_done) begin
                    bank_nxt[wr_bank] = B_FULL;
                    wr_nxt            = ~wr_bank;
                    produced_nxt      = produced + CNT_ONE;
                    p_state_nxt       = P_IDLE;
                end
            end
            default: p_state_nxt = P_IDLE;
        endcase

        // Consumer
        case (c_state)
            C_IDLE: begin
                if (cons_done) begin
                    err_nxt = 1'b1;
                end
                if (bank_st[rd_bank] == B_FULL) begin
                    cons_start_nxt    = 1'b1;
                    bank_nxt[rd_bank] = B_READING;
                    c_state_nxt       = C_BUSY;
                end
            end
            C_BUSY: begin
                if (cons_done) begin
                    bank_nxt[rd_bank] = B_EMPTY;
                    rd_nxt            = ~rd_bank;
                    frames_nxt        = frames_done + CNT_ONE;
                    c_state_nxt       = C_IDLE;
                end
            end
            default: c_state_nxt = C_IDLE;
        endcase

        // Layer boundary: frames_done reached the limit on the previous
        // edge. The consumer is idle here, so no increment is lost. The
        // producer cannot start either, because produced equals the limit.
        if (limit_hit) begin
            layer_nxt    = 1'b1;
            frames_nxt   = '0;
            produced_nxt = '0;
        end
    end

    assign bank_full = {bank_st[1][1], bank_st[0][1]};

endmodule
`default_nettype wire

// File: tb/tb_convb_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_convb_pingpong_ctrl
//  Purpose  : Self-checking bench for convb_pingpong_ctrl (FRAME_LIMIT=4).
//             A cycle table covers reset, first-frame latency, simultaneous
//             done and protocol errors. Hand-written sequences cover the
//             full-bank stall, mid-frame reset and a complete layer pass.
//  Revision : 1.0  initial release
// ============================================================================
module tb_convb_pingpong_ctrl;

    localparam int FL = 4;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          prod_done = 1'b0;
    logic          cons_done = 1'b0;
    logic          prod_start, cons_start, wr_bank, rd_bank;
    logic          layer_done, proto_err;
    logic [1:0]    bank_full;
    logic [CB-1:0] frames_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    convb_pingpong_ctrl #(.FRAME_LIMIT(FL), .CNT_BITS(CB)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .prod_done  (prod_done),
        .cons_done  (cons_done),
        .prod_start (prod_start),
        .cons_start (cons_start),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .bank_full  (bank_full),
        .frames_done(frames_done),
        .layer_done (layer_done),
        .proto_err  (proto_err)
    );

    // One cycle record: inputs held before the edge and outputs after it.
    typedef struct {
        logic [3:0]  in;   // {reset, run, prod_done, cons_done}
        logic [15:0] exp;  // {ps, cs, wb, rb, bank_full[1:0], frames_done[7:0], ld, pe}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [3:0] in, input logic [3:0] sp,
                                 input logic [1:0] bf, input logic [7:0] fd,
                                 input logic [1:0] fl);
        vec_t v;
        v.in  = in;
        v.exp = {sp, bf, fd, fl};
        return v;
    endfunction

    function automatic logic [15:0] outs();
        return {prod_start, cons_start, wr_bank, rd_bank, bank_full, frames_done,
                layer_done, proto_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_pd();
        prod_done = 1'b1;
        tick();
        prod_done = 1'b0;
    endtask

    task automatic pulse_cd();
        cons_done = 1'b1;
        tick();
        cons_done = 1'b0;
    endtask

    // Waits, bounded, until the selected start pulse is visible.
    task automatic wait_start(input bit cons, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((cons ? cons_start : prod_start) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit seen;
        int cnt;
        int nps, ncs, nld;
        bit got_ld;
        logic [CB-1:0] prev_fd, fd_prev_ld, fd_at_ld;

        // ---------------- table: reset, first frame, simultaneous done ----
        vecs.push_back(mkv(4'b0000, 4'b0000, 2'b00, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b0100, 4'b0000, 2'b00, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b1100, 4'b1000, 2'b00, 8'd0, 2'b00)); // edge 1
        for (int k = 0; k < 9; k++)                                  // edges 2..10
            vecs.push_back(mkv(4'b1100, 4'b0000, 2'b00, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b1110, 4'b0010, 2'b01, 8'd0, 2'b00)); // edge 11: prod_done
        vecs.push_back(mkv(4'b1100, 4'b1110, 2'b01, 8'd0, 2'b00)); // edge 12: both start
        vecs.push_back(mkv(4'b1100, 4'b0010, 2'b01, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b1111, 4'b0001, 2'b10, 8'd1, 2'b00)); // simultaneous done
        vecs.push_back(mkv(4'b1100, 4'b1101, 2'b10, 8'd1, 2'b00));
        vecs.push_back(mkv(4'b1100, 4'b0001, 2'b10, 8'd1, 2'b00));
        // ---------------- table: protocol errors ---------------------------
        vecs.push_back(mkv(4'b0000, 4'b0000, 2'b00, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b1000, 4'b0000, 2'b00, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b1001, 4'b0000, 2'b00, 8'd0, 2'b01)); // cons_done idle
        vecs.push_back(mkv(4'b1000, 4'b0000, 2'b00, 8'd0, 2'b01)); // sticky
        vecs.push_back(mkv(4'b0000, 4'b0000, 2'b00, 8'd0, 2'b00)); // reset clears
        vecs.push_back(mkv(4'b1000, 4'b0000, 2'b00, 8'd0, 2'b00));
        vecs.push_back(mkv(4'b1010, 4'b0000, 2'b00, 8'd0, 2'b01)); // prod_done idle
        vecs.push_back(mkv(4'b1100, 4'b1000, 2'b00, 8'd0, 2'b01)); // still runs, sticky
        vecs.push_back(mkv(4'b0000, 4'b0000, 2'b00, 8'd0, 2'b00));

        foreach (vecs[i]) begin
            {reset, run, prod_done, cons_done} = vecs[i].in;
            tick();
            check($sformatf("vec[%0d] {ps,cs,wb,rb,bf,fd,ld,pe}", i),
                  32'(outs()), 32'(vecs[i].exp));
        end
        {reset, run, prod_done, cons_done} = 4'b0000;

        // ---------------- both banks full: producer stalls -----------------
        reset = 1'b1;
        run   = 1'b1;
        wait_start(1'b0, 10, seen);
        check("stall first prod_start seen", 32'(seen), 1);
        check("stall first wr_bank", 32'(wr_bank), 0);
        pulse_pd();
        wait_start(1'b0, 10, seen);
        check("stall second prod_start seen", 32'(seen), 1);
        check("stall second wr_bank", 32'(wr_bank), 1);
        pulse_pd();
        check("stall bank_full after fill", 32'(bank_full), 3);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (prod_start) cnt++;
        end
        check("stall prod_start count in 50 cycles", 32'(cnt), 0);
        check("stall bank_full held", 32'(bank_full), 3);
        check("stall proto_err", 32'(proto_err), 0);
        pulse_cd();
        check("release prod_start 1 cycle after", 32'(prod_start), 0);
        tick();
        check("release prod_start 2 cycles after", 32'(prod_start), 1);
        check("release wr_bank", 32'(wr_bank), 0);
        check("release cons_start/rd_bank", 32'({cons_start, rd_bank}), 3);
        check("release frames_done", 32'(frames_done), 1);

        // ---------------- reset mid-frame with both banks holding frames ---
        pulse_pd();
        check("midreset bank_full before", 32'(bank_full), 3);
        reset = 1'b0;
        tick();
        check("midreset outputs", 32'(outs()), 0);
        reset = 1'b1;
        run   = 1'b1;
        tick();
        check("midreset restart {ps,wb,bf}", 32'({prod_start, wr_bank, bank_full}), 32'h8);

        // ---------------- complete layer pass with FRAME_LIMIT=4 -----------
        reset = 1'b0;
        run   = 1'b0;
        tick();
        reset  = 1'b1;
        run    = 1'b1;
        nps    = 0;
        ncs    = 0;
        nld    = 0;
        got_ld = 1'b0;
        prev_fd    = '0;
        fd_prev_ld = '0;
        fd_at_ld   = '1;
        for (int i = 0; i < 300 && !got_ld; i++) begin
            tick();
            if (prod_start) nps++;
            if (cons_start) ncs++;
            if (layer_done) begin
                nld++;
                got_ld     = 1'b1;
                fd_at_ld   = frames_done;
                fd_prev_ld = prev_fd;
                run        = 1'b0;
            end
            prev_fd   = frames_done;
            prod_done = prod_start;
            cons_done = cons_start;
        end
        prod_done = 1'b0;
        cons_done = 1'b0;
        check("layer layer_done seen", 32'(got_ld), 1);
        check("layer frames_done before pulse", 32'(fd_prev_ld), FL);
        check("layer frames_done at pulse", 32'(fd_at_ld), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (prod_start) nps++;
            if (cons_start) ncs++;
            if (layer_done) nld++;
        end
        check("layer prod_start count", 32'(nps), FL);
        check("layer cons_start count", 32'(ncs), FL);
        check("layer layer_done count", 32'(nld), 1);
        check("layer frames_done after", 32'(frames_done), 0);
        check("layer proto_err", 32'(proto_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
